// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, addresses the
// combinational instruction memory and holds the IF/ID register. Decode reads
// the IF/ID register through a valid/ready handshake. Redirects from execute
// flush the register. A misaligned redirect target latches a sticky trap.
module fetch_unit #(
   parameter int          DWIDTH   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              nReset,
   output logic [31:0]       imem_addr,
   input  logic [DWIDTH-1:0] imem_instr,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [DWIDTH-1:0] id_instr,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_pc4,
   output logic              misalign,
   output logic [31:0]       fetch_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] TRAP = 2'd2;

   logic [1:0]  state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] pc_plus4;
   logic        capture;
   logic        flush;
   logic        trap_set;
   logic        tgt_misaligned;
   logic        xfer;

   // The memory takes a word index. This holds in every state, including TRAP.
   assign imem_addr      = {2'b00, pc[31:2]};
   assign pc_plus4       = pc + 32'd4;
   assign tgt_misaligned = (redirect_pc[1:0] != 2'b00);
   // Decode has taken the current entry. A flush in the same cycle still counts it.
   assign xfer           = id_valid & id_ready;

   // Next-state decode. A redirect beats stall and capture. TRAP ignores all inputs.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      capture   = 1'b0;
      flush     = 1'b0;
      trap_set  = 1'b0;
      case (state)
         IDLE: begin
            if (redirect_valid) begin
               pc_nxt = redirect_pc;
               flush  = 1'b1;
               if (tgt_misaligned) begin
                  trap_set  = 1'b1;
                  state_nxt = TRAP;
               end else begin
                  state_nxt = RUN;
               end
            end else begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               pc_nxt = redirect_pc;
               flush  = 1'b1;
               if (tgt_misaligned) begin
                  trap_set  = 1'b1;
                  state_nxt = TRAP;
               end
            end else if (!id_valid || id_ready) begin
               capture = 1'b1;
               pc_nxt  = pc_plus4;
            end
         end
         TRAP: begin
            state_nxt = TRAP;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM state and program counter.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // IF/ID register. A flush clears only the valid bit. The payload is don't-care until the next capture.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= 32'd0;
         id_pc4   <= 32'd0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (capture) begin
         id_valid <= 1'b1;
         id_instr <= imem_instr;
         id_pc    <= pc;
         id_pc4   <= pc_plus4;
      end
   end

   // Sticky misalign trap flag. Only reset clears it.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)
         misalign <= 1'b0;
      else if (trap_set)
         misalign <= 1'b1;
   end

   // Wrapping count of instructions accepted by decode.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)
         fetch_count <= 32'd0;
      else if (xfer)
         fetch_count <= fetch_count + 32'd1;
   end

endmodule
